// File: rtl/sys_grid_ctrl.sv
// rtl/sys_grid_ctrl.sv - TILE_R x TILE_C weight-stationary systolic grid with job sequencer
// Optional macro SYS_GRID_PERF_CNT_EN adds perf_busy_cyc / perf_stall_cyc counters.
module sys_grid_ctrl #(
  parameter int TILE_R = 2,
  parameter int TILE_C = 2,
  parameter int SR     = 8,
  parameter int SC     = 8,
  parameter int AW     = 8,
  parameter int WW     = 8,
  parameter int PW     = 32,
  parameter int CNT_W  = 16
) (
`ifdef SYS_GRID_PERF_CNT_EN
  output logic [31:0]                    perf_busy_cyc,
  output logic [31:0]                    perf_stall_cyc,
`endif
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_mode,
  input  logic [CNT_W-1:0]               cmd_nvec,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [TILE_C*SC*WW-1:0]        w_data,
  input  logic [TILE_C*SC*PW-1:0]        bias,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [TILE_R*SR*AW-1:0]        a_data,
  output logic [TILE_R*TILE_C*SC*PW-1:0] of_data,
  output logic [TILE_R-1:0]              o_valid,
  output logic                           o_first,
  output logic                           o_last,
  output logic                           busy
);
  localparam int NR = TILE_R * SR;
  localparam int NC = TILE_C * SC;

  typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DRAIN} state_e;
  state_e state_q, state_d;

  logic              mode_q;
  logic [CNT_W-1:0]  nvec_q, wcnt_q, acnt_q, dcnt_q, ocnt_q;
  logic [NC*PW-1:0]  bias_q;
  logic [NC*WW-1:0]  wt_q [NR];
  logic [NR*AW-1:0]  in_q;
  logic              in_v_q;
  logic [AW-1:0]     sk_q [NR][NR];
  logic [NR-1:0]     if_en_q;
  logic [NC*PW-1:0]  ps_q [NR];
  logic [NC*PW-1:0]  ps_d [NR];
  logic [NC*PW-1:0]  of_q [TILE_R];
  logic [TILE_R-1:0] ov_q;
  logic              first_q, last_q;

  logic              cmd_acc, w_acc, a_acc, wfetch, wfetch_halt, out_fire;
  logic [CNT_W-1:0]  wdepth, ddepth;
  logic [AW-1:0]     act_src [NR];
  logic [AW-1:0]     act [NR];
  logic [NC*PW-1:0]  up;
  logic signed [WW+AW-1:0] prod;
  logic [TILE_R-1:0] tile_v;

  assign cmd_acc     = cmd_valid && cmd_ready;
  assign w_acc       = w_valid && w_ready;
  assign a_acc       = a_valid && a_ready;
  assign wfetch      = (state_q == WLOAD);
  assign wfetch_halt = !w_valid;
  assign wdepth      = mode_q ? CNT_W'(SR) : CNT_W'(NR);
  // Drain holds LAT + NC - 1 cycles, i.e. DEPTH + 2 + NC - 1; counter runs 0..DEPTH+NC.
  assign ddepth      = mode_q ? CNT_W'(SR + NC) : CNT_W'(NR + NC);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = WLOAD;
      WLOAD:   if (w_acc && wcnt_q == wdepth - CNT_W'(1)) state_d = STREAM;
      STREAM:  if (a_acc && acnt_q == nvec_q - CNT_W'(1)) state_d = DRAIN;
      DRAIN:   if (dcnt_q == ddepth) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    w_ready   = (state_q == WLOAD);
    a_ready   = (state_q == STREAM);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= 1'b0;
      nvec_q <= '0;
      bias_q <= '0;
      wcnt_q <= '0;
      acnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (cmd_acc) begin
        mode_q <= cmd_mode;
        nvec_q <= (cmd_nvec == '0) ? CNT_W'(1) : cmd_nvec;
        bias_q <= bias;
        wcnt_q <= '0;
        acnt_q <= '0;
      end else begin
        if (w_acc) wcnt_q <= wcnt_q + CNT_W'(1);
        if (a_acc) acnt_q <= acnt_q + CNT_W'(1);
      end
      dcnt_q <= (state_q == DRAIN) ? dcnt_q + CNT_W'(1) : '0;
    end
  end

  // Weight rows shift top-down; a tile-row top takes w_data directly unless fused below row 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NR; g++) wt_q[g] <= '0;
    end else if (wfetch && !wfetch_halt) begin
      for (int g = 0; g < NR; g++)
        wt_q[g] <= ((g % SR == 0) && (mode_q || g == 0)) ? w_data : wt_q[(g + NR - 1) % NR];
    end
  end

  always_comb begin
    for (int g = 0; g < NR; g++) begin
      act_src[g] = mode_q ? in_q[(g % SR) * AW +: AW] : in_q[g * AW +: AW];
      if (mode_q) act[g] = (g % SR == 0) ? act_src[g] : sk_q[g][((g % SR) + NR - 1) % NR];
      else        act[g] = (g == 0) ? act_src[g] : sk_q[g][(g + NR - 1) % NR];
    end
  end

  always_comb begin
    up   = '0;
    prod = '0;
    for (int g = 0; g < NR; g++) begin
      ps_d[g] = '0;
      up = ((g % SR == 0) && (mode_q || g == 0)) ? bias_q : ps_q[(g + NR - 1) % NR];
      for (int j = 0; j < NC; j++) begin
        prod = $signed(wt_q[g][j * WW +: WW]) * $signed(act[g]);
        ps_d[g][j * PW +: PW] = up[j * PW +: PW] + PW'(prod);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_q    <= '0;
      in_v_q  <= 1'b0;
      if_en_q <= '0;
      for (int g = 0; g < NR; g++) begin
        ps_q[g] <= '0;
        for (int k = 0; k < NR; k++) sk_q[g][k] <= '0;
      end
    end else begin
      if (a_acc) in_q <= a_data;
      in_v_q  <= a_acc;
      if_en_q <= {if_en_q[NR-2:0], in_v_q};
      for (int g = 0; g < NR; g++) begin
        ps_q[g]    <= ps_d[g];
        sk_q[g][0] <= act_src[g];
        for (int k = 1; k < NR; k++) sk_q[g][k] <= sk_q[g][k-1];
      end
    end
  end

  always_comb begin
    tile_v = '0;
    for (int t = 0; t < TILE_R; t++)
      tile_v[t] = mode_q ? if_en_q[SR-1] : ((t == TILE_R - 1) && if_en_q[NR-1]);
  end
  assign out_fire = mode_q ? if_en_q[SR-1] : if_en_q[NR-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ov_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ocnt_q  <= '0;
      for (int t = 0; t < TILE_R; t++) of_q[t] <= '0;
    end else begin
      ov_q    <= tile_v;
      first_q <= out_fire && (ocnt_q == '0);
      last_q  <= out_fire && (ocnt_q == nvec_q - CNT_W'(1));
      ocnt_q  <= cmd_acc ? '0 : ocnt_q + CNT_W'(out_fire);
      for (int t = 0; t < TILE_R; t++)
        if (tile_v[t]) of_q[t] <= ps_q[t * SR + SR - 1];
    end
  end

  for (genvar t = 0; t < TILE_R; t++) begin : g_of
    assign of_data[t * NC * PW +: NC * PW] = of_q[t];
  end
  assign o_valid = ov_q;
  assign o_first = first_q;
  assign o_last  = last_q;

`ifdef SYS_GRID_PERF_CNT_EN
  logic [31:0] pbusy_q, pstall_q;
  logic        stall;
  assign stall = ((state_q == WLOAD) && !w_valid) || ((state_q == STREAM) && !a_valid);

  always_ff @(posedge clk) begin
    if (!rst || cmd_acc) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy && pbusy_q != 32'hFFFF_FFFF)   pbusy_q  <= pbusy_q + 32'd1;
      if (stall && pstall_q != 32'hFFFF_FFFF) pstall_q <= pstall_q + 32'd1;
    end
  end
  assign perf_busy_cyc  = pbusy_q;
  assign perf_stall_cyc = pstall_q;
`endif
endmodule
